uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 125_000_000, meaning system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning line rate in bit/s; BIT_TIME = CLOCK_FREQ/BAUD_RATE cycles (integer, truncated).
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame, legal 5..8.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame, legal 1..2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, meaning TX FIFO entries, power of two, >= 2.
REQ-007 SHALL have port clk, input, 1, meaning the single clock; all logic on posedge clk.
REQ-008 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-009 SHALL have port data_in, input, 8, meaning byte to send; only bits [DATA_BITS-1:0] are transmitted.
REQ-010 SHALL have port data_in_valid, input, 1, meaning data_in is offered.
REQ-011 SHALL have port data_in_ready, output, 1, meaning FIFO can accept the offered byte this cycle.
REQ-012 SHALL have port serial_out, output, 1, meaning UART line, idle high.
REQ-013 SHALL have port tx_busy, output, 1, meaning a frame is on the line or the FIFO is non-empty.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, meaning bytes held in the FIFO.

Function
REQ-015 SHALL accept a byte on any cycle with data_in_valid && data_in_ready; data_in_ready = (fifo_count != FIFO_DEPTH), registered-state derived, with no combinational path from data_in_valid.
REQ-016 SHALL ignore data_in_valid while full; no byte is dropped or overwritten, and offering while full has no effect.
REQ-017 SHALL give pop and push in the same cycle a net fifo_count change of 0; push while full is impossible, and pop while empty never occurs.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 SHALL transition IDLE->START on the cycle after FIFO non-empty, popping the head byte into a frame register in that transition cycle.
REQ-020 SHALL transition START->DATA after BIT_TIME cycles; DATA lasts DATA_BITS x BIT_TIME cycles, LSB first.
REQ-021 SHALL transition DATA->PARITY when PARITY != 0, else DATA->STOP; PARITY lasts BIT_TIME cycles.
REQ-022 SHALL compute the parity bit from the DATA_BITS payload bits: odd -> ~^payload, even -> ^payload.
REQ-023 SHALL drive serial_out high in STOP for STOP_BITS x BIT_TIME cycles, then go to START if FIFO non-empty (back-to-back, no idle gap), else IDLE.
REQ-024 SHALL register serial_out: 1 in IDLE/STOP, 0 in START, current payload bit in DATA, parity in PARITY; no glitches.
REQ-025 SHALL have latency: byte pushed at cycle N into an empty FIFO with FSM in IDLE -> serial_out falls at edge of cycle N+2.
REQ-026 SHALL give every bit exactly BIT_TIME cycles; a bit counter and a baud counter of width $clog2(BIT_TIME+1) SHALL both restart at each frame start.
REQ-027 SHALL drive tx_busy = (state != IDLE) || (fifo_count != 0).

Reset
REQ-028 SHALL on reset assertion immediately force state IDLE, serial_out 1, FIFO empty (fifo_count 0), data_in_ready 0 while reset is high, tx_busy 0, and counters 0.
REQ-029 SHALL abort a frame on reset mid-frame without completion, returning the line high; the flushed FIFO contents are lost.
REQ-030 SHALL assert data_in_ready on the first clk edge after reset deasserts.

Structure
REQ-031 SHALL place PARITY_NONE/ODD/EVEN constants and the FSM state encoding in shared package uart_pkg.
REQ-032 SHALL implement the FIFO as sub-module uart_tx_fifo (sync, registered count, push/pop/full/empty).

Verification (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 -> BIT_TIME=10)
REQ-033 SHALL cover 8N1: push 0xA5 at cycle 0 -> line low from cycle 2 for 10 cycles, then 1,0,1,0,0,1,0,1 each 10 cycles, then high 10 cycles; tx_busy falls at cycle 102.
REQ-034 SHALL cover 7E2: push 0x53 -> 7 data bits 1,1,0,0,1,0,1, parity 0, then 20 high cycles; frame 110 cycles.
REQ-035 SHALL cover backpressure: FIFO_DEPTH=4, hold valid for 6 bytes 0x01..0x06 -> data_in_ready low after the first FIFO fills; all 6 bytes are transmitted in order, back-to-back, with no idle gap between stop and start.
REQ-036 SHALL cover reset during DATA bit 3 of 0xFF -> serial_out 1 within the same cycle, fifo_count 0, and the next pushed byte 0x0F sent cleanly.
REQ-037 SHALL cover 5O1: push 0x1F -> data bits 1,1,1,1,1, parity 0 (odd), and upper bits [7:5] are ignored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity mode constants, the
// transmit FSM state encoding and a parity helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Parity over the low data_bits bits of payload; bits above data_bits are ignored.
  function automatic logic parity_bit(input logic [7:0]  payload,
                                      input int unsigned data_bits,
                                      input int unsigned parity);
    logic x;
    x = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < data_bits) x ^= payload[i];
    end
    return (parity == PARITY_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO with a registered occupancy count.
// Ports: clk, reset (async, active high), push/push_data write side,
// pop/pop_data read side (pop_data shows the head entry), full, empty, count.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == (AddrW + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_q];
  assign count    = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a small input FIFO.
// Ports: clk, reset (async, active high); data_in/data_in_valid/data_in_ready
// byte handshake; serial_out registered line (idle high); tx_busy while a
// frame is on the line or bytes are queued; fifo_count bytes held.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BitTime = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CntW    = $clog2(BitTime + 1);

  uart_state_e     state_q;
  logic [CntW-1:0] baud_cnt_q, bit_cnt_q;
  logic [7:0]      frame_q;
  logic            parity_q;
  logic            serial_q;
  logic            ready_en_q;

  logic       push, pop, full, empty;
  logic [7:0] head;
  logic       bit_done, last_data, last_stop;

  // ready_en_q keeps the FIFO closed during reset and opens it on the first edge after.
  assign data_in_ready = ready_en_q && !full;
  assign push          = data_in_valid && data_in_ready;

  assign bit_done  = (baud_cnt_q == CntW'(BitTime - 1));
  assign last_data = (bit_cnt_q == CntW'(DATA_BITS - 1));
  assign last_stop = (bit_cnt_q == CntW'(STOP_BITS - 1));

  // Pop exactly when the FSM loads a new frame: from idle, or back-to-back at end of stop.
  assign pop = !empty && ((state_q == StIdle) ||
                          ((state_q == StStop) && bit_done && last_stop));

  assign serial_out = serial_q;
  assign tx_busy    = (state_q != StIdle) || (fifo_count != '0);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (data_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      frame_q    <= '0;
      parity_q   <= 1'b0;
      serial_q   <= 1'b1;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (state_q != StIdle) begin
        baud_cnt_q <= bit_done ? '0 : baud_cnt_q + 1'b1;
      end
      case (state_q)
        StIdle: begin
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
          serial_q   <= 1'b1;
          if (pop) begin
            state_q  <= StStart;
            frame_q  <= head;
            parity_q <= parity_bit(head, DATA_BITS, PARITY);
            serial_q <= 1'b0;
          end
        end
        StStart: begin
          if (bit_done) begin
            state_q   <= StData;
            bit_cnt_q <= '0;
            serial_q  <= frame_q[0];
          end
        end
        StData: begin
          if (bit_done) begin
            if (last_data) begin
              bit_cnt_q <= '0;
              if (PARITY != PARITY_NONE) begin
                state_q  <= StParity;
                serial_q <= parity_q;
              end else begin
                state_q  <= StStop;
                serial_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              frame_q   <= frame_q >> 1;
              serial_q  <= frame_q[1];
            end
          end
        end
        StParity: begin
          if (bit_done) begin
            state_q   <= StStop;
            bit_cnt_q <= '0;
            serial_q  <= 1'b1;
          end
        end
        StStop: begin
          if (bit_done) begin
            if (last_stop) begin
              bit_cnt_q <= '0;
              if (pop) begin
                state_q  <= StStart;
                frame_q  <= head;
                parity_q <= parity_bit(head, DATA_BITS, PARITY);
                serial_q <= 1'b0;
              end else begin
                state_q  <= StIdle;
                serial_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          serial_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (8N1, 7E2, 5O1) at BIT_TIME = 10,
// a frame-level line model per instance, a per-cycle compare and directed
// literal checks.
module tb_uart_tx_param;

  localparam int Bt    = 10;
  localparam int Depth = 4;
  localparam int Qn    = 4096;

  int db [3] = '{8, 7, 5};
  int par[3] = '{0, 2, 1};
  int sb [3] = '{1, 2, 1};

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] valid;
  logic [7:0] din  [3];
  logic [2:0] rdy, sout, busy;
  logic [2:0] fcnt [3];

  always #5 clk = ~clk;

  uart_tx_param #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(Depth)) dut_8n1 (
    .clk(clk), .reset(reset), .data_in(din[0]), .data_in_valid(valid[0]),
    .data_in_ready(rdy[0]), .serial_out(sout[0]), .tx_busy(busy[0]), .fifo_count(fcnt[0]));

  uart_tx_param #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(Depth)) dut_7e2 (
    .clk(clk), .reset(reset), .data_in(din[1]), .data_in_valid(valid[1]),
    .data_in_ready(rdy[1]), .serial_out(sout[1]), .tx_busy(busy[1]), .fifo_count(fcnt[1]));

  uart_tx_param #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(5), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(Depth)) dut_5o1 (
    .clk(clk), .reset(reset), .data_in(din[2]), .data_in_valid(valid[2]),
    .data_in_ready(rdy[2]), .serial_out(sout[2]), .tx_busy(busy[2]), .fifo_count(fcnt[2]));

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(string nm, int i, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %0d expected %0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Line model: a queue of future line levels, one entry per clock cycle.
  logic lq_val [3][Qn];
  logic lq_st  [3][Qn];
  int   head [3] = '{0, 0, 0};
  int   tail [3] = '{0, 0, 0};
  int   cnt  [3] = '{0, 0, 0};
  logic rdy_en [3] = '{1'b0, 1'b0, 1'b0};
  logic m_val  [3] = '{1'b1, 1'b1, 1'b1};
  logic m_busy [3] = '{1'b0, 1'b0, 1'b0};

  task automatic q_put(int i, logic v, logic st);
    lq_val[i][tail[i]] = v;
    lq_st[i][tail[i]]  = st;
    tail[i] = (tail[i] + 1) % Qn;
  endtask

  // Append a whole frame: start, payload LSB first, optional parity, stop bits.
  task automatic m_append(int i, logic [7:0] d);
    logic [7:0] p;
    logic       bits [12];
    int         n;
    p = d & 8'((1 << db[i]) - 1);
    n = 0;
    bits[n] = 1'b0; n = n + 1;
    for (int k = 0; k < db[i]; k++) begin bits[n] = p[k]; n = n + 1; end
    if (par[i] != 0) begin
      bits[n] = (par[i] == 1) ? ~(^p) : (^p);
      n = n + 1;
    end
    for (int s = 0; s < sb[i]; s++) begin bits[n] = 1'b1; n = n + 1; end
    for (int b = 0; b < n; b++)
      for (int c = 0; c < Bt; c++) q_put(i, bits[b], (b == 0) && (c == 0));
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        head[i] = 0; tail[i] = 0; cnt[i] = 0;
        rdy_en[i] = 1'b0; m_val[i] = 1'b1; m_busy[i] = 1'b0;
      end else begin
        if (valid[i] && rdy_en[i] && cnt[i] != Depth) begin
          cnt[i]++;
          // An idle line spends one cycle noticing the byte before the start bit.
          if (head[i] == tail[i]) q_put(i, 1'b1, 1'b0);
          m_append(i, din[i]);
        end
        if (head[i] != tail[i]) begin
          m_val[i] = lq_val[i][head[i]];
          if (lq_st[i][head[i]]) cnt[i]--;
          head[i] = (head[i] + 1) % Qn;
          m_busy[i] = 1'b1;
        end else begin
          m_val[i] = 1'b1;
          m_busy[i] = 1'b0;
        end
        rdy_en[i] = 1'b1;
      end
    end
  end

  logic run = 1'b0;
  initial forever begin
    @(negedge clk);
    if (run) begin
      for (int i = 0; i < 3; i++) begin
        chk("serial", i, 8'(sout[i]), 8'(m_val[i]));
        chk("ready",  i, 8'(rdy[i]),  8'(rdy_en[i] && (cnt[i] != Depth)));
        chk("busy",   i, 8'(busy[i]), 8'(m_busy[i]));
        chk("count",  i, 8'(fcnt[i]), 8'(cnt[i]));
      end
    end
  end

  // Literal expectations relative to the push cycle (cycle 0).
  int   lc [24];
  int   lk [24];
  logic lv [24];
  int   ln = 0;

  task automatic lit_clear();
    ln = 0;
  endtask

  task automatic lit_add(int k, int c, logic v);
    lk[ln] = k; lc[ln] = c; lv[ln] = v; ln++;
  endtask

  task automatic push_check(int i, logic [7:0] d, int last);
    @(negedge clk);
    din[i] = d;
    valid[i] = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) valid[i] = 1'b0;
      for (int e = 0; e < ln; e++) begin
        if (lc[e] == c) begin
          if (lk[e] == 0) chk("lit_serial", i, 8'(sout[i]), 8'(lv[e]));
          else            chk("lit_busy",   i, 8'(busy[i]), 8'(lv[e]));
        end
      end
    end
  endtask

  task automatic wait_idle(int i, int budget);
    int g;
    g = 0;
    while (busy[i] && g < budget) begin
      @(negedge clk);
      g++;
    end
    chk("idle_timeout", i, 8'(busy[i]), 8'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int   nb, g;
    logic a, saw_low;
    reset = 1'b1;
    valid = '0;
    for (int i = 0; i < 3; i++) din[i] = 8'h00;
    run = 1'b1;

    @(negedge clk);
    chk("rst_serial", 0, 8'(sout[0]), 8'd1);
    chk("rst_ready",  0, 8'(rdy[0]),  8'd0);
    chk("rst_busy",   0, 8'(busy[0]), 8'd0);
    chk("rst_count",  0, 8'(fcnt[0]), 8'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("ready_after_rst", i, 8'(rdy[i]), 8'd1);

    // 8N1, 0xA5
    lit_clear();
    lit_add(0, 1, 1'b1);  lit_add(0, 2, 1'b0);  lit_add(0, 11, 1'b0);
    lit_add(0, 12, 1'b1); lit_add(0, 22, 1'b0); lit_add(0, 32, 1'b1);
    lit_add(0, 42, 1'b0); lit_add(0, 52, 1'b0); lit_add(0, 62, 1'b1);
    lit_add(0, 72, 1'b0); lit_add(0, 82, 1'b1); lit_add(0, 92, 1'b1);
    lit_add(0, 101, 1'b1); lit_add(1, 101, 1'b1); lit_add(1, 102, 1'b0);
    push_check(0, 8'hA5, 103);
    wait_idle(0, 200);

    // 7E2, 0x53
    lit_clear();
    lit_add(0, 2, 1'b0);  lit_add(0, 12, 1'b1); lit_add(0, 22, 1'b1);
    lit_add(0, 32, 1'b0); lit_add(0, 42, 1'b0); lit_add(0, 52, 1'b1);
    lit_add(0, 62, 1'b0); lit_add(0, 72, 1'b1); lit_add(0, 82, 1'b0);
    lit_add(0, 92, 1'b1); lit_add(0, 111, 1'b1);
    lit_add(1, 111, 1'b1); lit_add(1, 112, 1'b0);
    push_check(1, 8'h53, 113);
    wait_idle(1, 200);

    // 5O1, 0x1F then 0xFF (upper bits must not change the line)
    lit_clear();
    lit_add(0, 2, 1'b0);  lit_add(0, 12, 1'b1); lit_add(0, 22, 1'b1);
    lit_add(0, 32, 1'b1); lit_add(0, 42, 1'b1); lit_add(0, 52, 1'b1);
    lit_add(0, 62, 1'b0); lit_add(0, 72, 1'b1);
    lit_add(1, 81, 1'b1); lit_add(1, 82, 1'b0);
    push_check(2, 8'h1F, 83);
    wait_idle(2, 200);
    push_check(2, 8'hFF, 83);
    wait_idle(2, 200);

    // Backpressure: six bytes offered continuously to a four-entry FIFO
    @(negedge clk);
    nb = 0; g = 0; saw_low = 1'b0;
    din[0] = 8'h01;
    valid[0] = 1'b1;
    while (nb < 6 && g < 1000) begin
      if (!rdy[0]) saw_low = 1'b1;
      a = rdy[0];
      @(negedge clk);
      g++;
      if (a) begin
        nb++;
        din[0] = 8'(nb + 1);
      end
    end
    valid[0] = 1'b0;
    chk("bp_accepted", 0, 8'(nb), 8'd6);
    chk("bp_ready_low", 0, 8'(saw_low), 8'd1);
    wait_idle(0, 1000);

    // Reset during data bit 3 of 0xFF with a second byte still queued
    @(negedge clk);
    din[0] = 8'hFF; valid[0] = 1'b1;
    @(negedge clk);
    din[0] = 8'h00;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (43) @(negedge clk);
    chk("pre_rst_count", 0, 8'(fcnt[0]), 8'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_serial", 0, 8'(sout[0]), 8'd1);
    chk("mid_rst_count",  0, 8'(fcnt[0]), 8'd0);
    chk("mid_rst_ready",  0, 8'(rdy[0]),  8'd0);
    chk("mid_rst_busy",   0, 8'(busy[0]), 8'd0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst2", 0, 8'(rdy[0]), 8'd1);
    repeat (20) @(negedge clk);

    lit_clear();
    lit_add(0, 2, 1'b0);  lit_add(0, 12, 1'b1); lit_add(0, 22, 1'b1);
    lit_add(0, 32, 1'b1); lit_add(0, 42, 1'b1); lit_add(0, 52, 1'b0);
    lit_add(0, 62, 1'b0); lit_add(0, 72, 1'b0); lit_add(0, 82, 1'b0);
    lit_add(0, 92, 1'b1); lit_add(1, 102, 1'b0);
    push_check(0, 8'h0F, 103);
    wait_idle(0, 200);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
